// File: rtl/uk101_pkg.sv
// rtl/uk101_pkg.sv - shared types and constants for the ASCII load sequencer
// Purpose: state encoding of the keystroke output FSM and the ASCII/ioctl
//          constants used when filtering and pacing the "Load Ascii" stream.
// Ports:   none (package).
package uk101_pkg;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_PRESENT,
    LS_GAP
  } ls_state_t;

  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] IOCTL_IDX_ASCII = 8'd0;

endpackage

// File: rtl/ls_fifo.sv
// rtl/ls_fifo.sv - small synchronous byte FIFO with occupancy count
// Purpose: buffers file bytes between hps_io writes and paced ACIA delivery.
//          A write and a pop in the same cycle both take effect; a write while
//          full is accepted only if a pop frees a slot in that same cycle.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_wr, i_wdata      write strobe and data
//   i_rd               pop strobe (ignored when empty)
//   o_rdata            head entry (valid when !o_empty)
//   o_count            number of stored entries, 0..DEPTH
//   o_full, o_empty    occupancy flags
module ls_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_rd,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_rd) r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ascii_load_sequencer.sv
// rtl/ascii_load_sequencer.sv - paces the OSD ASCII file into the ACIA receive path
// Purpose: turns the hps_io "Load Ascii" download into keystrokes separated by
//          a per-character or per-line idle gap, and muxes the ACIA receive
//          byte between this stream and the UART deserializer.
// Ports:
//   clk_sys, reset                      clock, synchronous active-high reset
//   load_from                           source select: 0 file, 1 UART
//   ioctl_download/index/wr/data        hps_io download interface
//   ioctl_wait                          backpressure to hps_io
//   uart_valid, uart_data               byte strobe from UART deserializer
//   rx_valid, rx_data, rx_ack           byte handshake toward the ACIA
//   busy                                file session active or bytes pending
//   overflow                            sticky: a file byte was dropped
module ascii_load_sequencer
  import uk101_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CHAR_GAP  = 48000,
  parameter int LINE_GAP  = 4800000,
  parameter int FILTER_LF = 1,
  parameter int GAP_W     = 23
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       busy,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    WAIT_LVL   = CW'(DEPTH - 2);
  localparam logic [GAP_W-1:0] CHAR_RELD  = GAP_W'(CHAR_GAP - 1);
  localparam logic [GAP_W-1:0] LINE_RELD  = GAP_W'(LINE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  ls_state_t        r_state;
  ls_state_t        w_state_nxt;
  logic             r_src;
  logic             r_session;
  logic             r_dl_d;
  logic             r_wait;
  logic             r_overflow;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_file_data;
  logic [7:0]       r_uart_data;
  logic             r_uart_valid;

  logic [CW-1:0]    w_count;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_start;
  logic             w_sess;
  logic             w_is_lf;
  logic             w_wr;
  logic             w_ack_file;
  logic             w_end;
  logic             w_load;

  // A session opens on the download rising edge for the ASCII slot, only when
  // the file source is selected; w_sess lets the opening cycle accept a byte.
  assign w_start    = ioctl_download & ~r_dl_d & (ioctl_index == IOCTL_IDX_ASCII) & ~r_src;
  assign w_sess     = r_session | w_start;
  assign w_is_lf    = (FILTER_LF != 0) && (ioctl_data == ASCII_LF);
  assign w_wr       = ioctl_wr & w_sess & ~w_is_lf;
  assign w_ack_file = rx_ack & (r_state == LS_PRESENT) & ~r_src;
  assign w_end      = r_session & ~ioctl_download & w_empty & (r_state == LS_IDLE);

  ls_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (clk_sys),
    .i_reset (reset),
    .i_wr    (w_wr),
    .i_wdata (ioctl_data),
    .i_rd    (w_ack_file),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      LS_IDLE: begin
        if (~r_src && ~w_empty) begin
          w_state_nxt = LS_PRESENT;
          w_load      = 1'b1;
        end
      end
      LS_PRESENT: begin
        if (w_ack_file) w_state_nxt = LS_GAP;
      end
      LS_GAP: begin
        if (r_gap == '0) w_state_nxt = LS_IDLE;
      end
      default: w_state_nxt = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= LS_IDLE;
      r_src        <= load_from;
      r_session    <= 1'b0;
      r_dl_d       <= 1'b0;
      r_wait       <= 1'b0;
      r_overflow   <= 1'b0;
      r_gap        <= '0;
      r_file_data  <= '0;
      r_uart_data  <= '0;
      r_uart_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dl_d  <= ioctl_download;

      // Source only switches between sessions so a file always drains fully.
      if (r_state == LS_IDLE && ~w_sess) r_src <= load_from;

      if (w_start)    r_session <= 1'b1;
      else if (w_end) r_session <= 1'b0;

      if (w_start)                          r_overflow <= 1'b0;
      else if (w_wr & w_full & ~w_ack_file) r_overflow <= 1'b1;

      // Registered, so asserts one cycle late; the two-slot margin absorbs
      // the write hps_io may already have in flight.
      r_wait <= w_sess & (w_count >= WAIT_LVL);

      if (w_load) r_file_data <= w_head;

      if (w_ack_file)
        r_gap <= (r_file_data == ASCII_CR) ? LINE_RELD : CHAR_RELD;
      else if (r_state == LS_GAP && r_gap != '0)
        r_gap <= r_gap - GAP_ONE;

      // One-deep holding register; a newer byte overwrites an unread one.
      if (~r_src) begin
        r_uart_valid <= 1'b0;
      end else if (uart_valid) begin
        r_uart_valid <= 1'b1;
        r_uart_data  <= uart_data;
      end else if (rx_ack) begin
        r_uart_valid <= 1'b0;
      end
    end
  end

  assign rx_valid   = r_src ? r_uart_valid : (r_state == LS_PRESENT);
  assign rx_data    = r_src ? r_uart_data : r_file_data;
  assign busy       = r_session | (w_count != '0) | (r_state != LS_IDLE);
  assign overflow   = r_overflow;
  assign ioctl_wait = r_wait;

endmodule

// File: tb/tb_ascii_load_sequencer.sv
// tb/tb_ascii_load_sequencer.sv - self-checking bench for ascii_load_sequencer
module tb_ascii_load_sequencer;
  localparam int DEPTH    = 8;
  localparam int CHAR_GAP = 4;
  localparam int LINE_GAP = 20;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       load_from = 1'b0;
  logic       ioctl_download = 1'b0;
  logic [7:0] ioctl_index = 8'd0;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_data = 8'd0;
  logic       uart_valid = 1'b0;
  logic [7:0] uart_data = 8'd0;
  logic       rx_ack = 1'b0;
  logic       ioctl_wait;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  ascii_load_sequencer #(
    .DEPTH     (DEPTH),
    .CHAR_GAP  (CHAR_GAP),
    .LINE_GAP  (LINE_GAP),
    .FILTER_LF (1),
    .GAP_W     (23)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .load_from      (load_from),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .uart_valid     (uart_valid),
    .uart_data      (uart_data),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ack         (rx_ack),
    .busy           (busy),
    .overflow       (overflow)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic src);
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    rx_ack = 1'b0;
    uart_valid = 1'b0;
    load_from = src;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    ioctl_data = b;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic uart_byte(input logic [7:0] b);
    uart_data = b;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
  endtask

  // Waits (bounded) for rx_valid; n is the number of cycles waited.
  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (rx_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, {31'd0, rx_valid}, 1);
  endtask

  task automatic ack_byte(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  task automatic take(input string tag, input logic [7:0] exp);
    int n;
    wait_valid(tag, 60, n);
    ack_byte(tag, exp);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (rx_valid === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  function automatic logic [7:0] rnd_char();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    int n;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] wq[$];
    logic [7:0] b;
    logic [7:0] b0, b1, b2, b3;
    int len, cyc, r;

    // Reset state
    do_reset(1'b0);
    chk("reset rx_valid", {31'd0, rx_valid}, 0);
    chk("reset rx_data", {24'd0, rx_data}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset overflow", {31'd0, overflow}, 0);
    chk("reset wait", {31'd0, ioctl_wait}, 0);

    // File "A\r\nB": LF dropped; gap = GAP length plus one presentation cycle
    start_dl(8'd0);
    chk("session busy", {31'd0, busy}, 1);
    write_byte(8'h41);
    chk("first latency", {31'd0, rx_valid}, 0);
    write_byte(CR);
    chk("first present", {31'd0, rx_valid}, 1);
    chk("first data", {24'd0, rx_data}, 32'h41);
    write_byte(LF);
    write_byte(8'h42);
    end_dl();
    ack_byte("file A", 8'h41);
    chk("after ack valid", {31'd0, rx_valid}, 0);
    wait_valid("file CR", 60, n);
    chk("char gap", n, CHAR_GAP + 1);
    ack_byte("file CR", CR);
    wait_valid("file B", 60, n);
    chk("line gap", n, LINE_GAP + 1);
    ack_byte("file B", 8'h42);
    check_quiet("no LF output", 40);
    chk("file done busy", {31'd0, busy}, 0);

    // Randomized file with random ack timing, wait honoured
    do_reset(1'b0);
    start_dl(8'd0);
    len = $urandom_range(8, 16);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? CR : (r == 1) ? LF : rnd_char();
      src_q.push_back(b);
      if (b != LF) exp_q.push_back(b);
    end
    cyc = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
      ioctl_wr = 1'b0;
      rx_ack = 1'b0;
      if (src_q.size() != 0 && ioctl_wait === 1'b0 && $urandom_range(0, 2) != 0) begin
        ioctl_data = src_q.pop_front();
        ioctl_wr = 1'b1;
      end
      if (rx_valid === 1'b1 && $urandom_range(0, 3) == 0) begin
        if (exp_q.size() == 0) chk("rand extra byte", {31'd0, rx_valid}, 0);
        else chk("rand data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        rx_ack = 1'b1;
      end
      tick();
      cyc++;
    end
    ioctl_wr = 1'b0;
    rx_ack = 1'b0;
    chk("rand drained", exp_q.size(), 0);
    chk("rand overflow", {31'd0, overflow}, 0);
    end_dl();
    check_quiet("rand quiet", 40);
    chk("rand busy", {31'd0, busy}, 0);

    // Burst without acks: wait at DEPTH-2, then forced writes to full and beyond
    do_reset(1'b0);
    start_dl(8'd0);
    for (int i = 0; i < 10; i++) begin
      if (ioctl_wait === 1'b0) begin
        b = rnd_char();
        write_byte(b);
        wq.push_back(b);
      end else begin
        tick();
      end
      tick();
      tick();
      chk("burst wait", {31'd0, ioctl_wait}, (wq.size() >= DEPTH - 2) ? 1 : 0);
    end
    chk("burst honoured overflow", {31'd0, overflow}, 0);
    while (wq.size() < DEPTH) begin
      b = rnd_char();
      write_byte(b);
      wq.push_back(b);
    end
    chk("full no overflow", {31'd0, overflow}, 0);
    write_byte(8'hEE);
    chk("overflow set", {31'd0, overflow}, 1);
    write_byte(8'hEF);
    end_dl();
    while (wq.size() != 0) take("burst drain", wq.pop_front());
    check_quiet("dropped absent", 40);
    chk("overflow sticky", {31'd0, overflow}, 1);
    start_dl(8'd0);
    chk("overflow cleared", {31'd0, overflow}, 0);
    end_dl();

    // Write and ack in the same cycle with three bytes stored
    do_reset(1'b0);
    start_dl(8'd0);
    b0 = rnd_char(); b1 = rnd_char(); b2 = rnd_char(); b3 = rnd_char();
    write_byte(b0);
    write_byte(b1);
    write_byte(b2);
    chk("same-cycle present", {31'd0, rx_valid}, 1);
    chk("same-cycle head", {24'd0, rx_data}, {24'd0, b0});
    ioctl_data = b3;
    ioctl_wr = 1'b1;
    rx_ack = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    rx_ack = 1'b0;
    end_dl();
    take("same-cycle b1", b1);
    take("same-cycle b2", b2);
    take("same-cycle b3", b3);
    check_quiet("same-cycle tail", 30);

    // UART pass-through
    do_reset(1'b1);
    uart_byte(8'h55);
    chk("uart valid", {31'd0, rx_valid}, 1);
    chk("uart data", {24'd0, rx_data}, 32'h55);
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    chk("uart ack clears", {31'd0, rx_valid}, 0);
    uart_byte(8'h33);
    chk("uart no gap", {31'd0, rx_valid}, 1);
    uart_byte(8'h22);
    chk("uart overwrite", {24'd0, rx_data}, 32'h22);
    ack_byte("uart ack", 8'h22);
    chk("uart busy", {31'd0, busy}, 0);

    // Source toggled mid-file: file drains first, UART follows
    do_reset(1'b0);
    start_dl(8'd0);
    b0 = rnd_char(); b1 = rnd_char(); b2 = rnd_char();
    write_byte(b0);
    load_from = 1'b1;
    write_byte(b1);
    write_byte(b2);
    end_dl();
    uart_byte(8'h99);
    take("toggle f0", b0);
    take("toggle f1", b1);
    take("toggle f2", b2);
    check_quiet("toggle quiet", 30);
    uart_byte(8'h77);
    chk("toggle uart valid", {31'd0, rx_valid}, 1);
    chk("toggle uart data", {24'd0, rx_data}, 32'h77);
    ack_byte("toggle uart ack", 8'h77);

    // Reset in GAP with 3 bytes queued, then a non-ASCII download
    do_reset(1'b0);
    start_dl(8'd0);
    b0 = rnd_char();
    write_byte(b0);
    write_byte(rnd_char());
    write_byte(rnd_char());
    write_byte(rnd_char());
    take("pre-reset", b0);
    ioctl_download = 1'b0;
    reset = 1'b1;
    tick();
    chk("gap reset rx_valid", {31'd0, rx_valid}, 0);
    chk("gap reset busy", {31'd0, busy}, 0);
    reset = 1'b0;
    start_dl(8'd1);
    write_byte(rnd_char());
    write_byte(rnd_char());
    check_quiet("idx1 no output", 20);
    chk("idx1 busy", {31'd0, busy}, 0);
    end_dl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
